// File: rtl/cell_plotter_if.sv
// Command handshake between the life simulation block and the cell plotter.
// The master presents a cell update and holds it until the slave raises in_ready.
interface cell_plotter_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_cell_x;
  logic [7:0] in_cell_y;
  logic [2:0] in_colour;

  modport master (output in_valid, output in_cell_x, output in_cell_y, output in_colour,
                  input  in_ready);
  modport slave  (input  in_valid, input  in_cell_x, input  in_cell_y, input  in_colour,
                  output in_ready);
endinterface

// File: rtl/cell_plotter.sv
// Cell plotter: queues cell-update commands and expands each one into a
// CELL_SIZE x CELL_SIZE block of single-pixel writes for the 160x120 VGA
// adapter. It can also sweep the whole screen with CLEAR_COLOUR on request.
module cell_plotter #(
  parameter int          CELL_SIZE    = 8,
  parameter int          GRID_W       = 4,
  parameter int          GRID_H       = 4,
  parameter int          X_OFFSET     = 0,
  parameter int          Y_OFFSET     = 0,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic          clock,
  input  logic          reset_n,
  cell_plotter_if.slave cmd,
  input  logic          clear_req,
  output logic          busy,
  output logic          err,
  output logic [7:0]    vga_x,
  output logic [7:0]    vga_y,
  output logic [2:0]    vga_colour,
  output logic          vga_plot
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       CELL_LAST  = 8'(CELL_SIZE - 1);
  localparam logic [7:0]       SCR_X_LAST = 8'(SCREEN_W - 1);
  localparam logic [7:0]       SCR_Y_LAST = 8'(SCREEN_H - 1);
  localparam logic [7:0]       GRID_W_C   = 8'(GRID_W);
  localparam logic [7:0]       GRID_H_C   = 8'(GRID_H);
  // Pixel arithmetic runs at 9 bits; the parameter ranges keep it below 256.
  localparam logic [8:0]       X_OFF_C    = 9'(X_OFFSET);
  localparam logic [8:0]       Y_OFF_C    = 9'(Y_OFFSET);
  localparam logic [8:0]       CELL_C     = 9'(CELL_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Command FIFO storage: {cell_x, cell_y, colour}
  logic [18:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  state_t     state_r;
  logic       clear_pending_r;
  logic [7:0] px_r;
  logic [7:0] py_r;
  logic [7:0] cx_r;
  logic [7:0] cy_r;
  logic [2:0] col_r;

  logic [7:0] vga_x_r;
  logic [7:0] vga_y_r;
  logic [2:0] vga_colour_r;
  logic       vga_plot_r;
  logic       err_r;

  logic        in_ready_s;
  logic        push_s;
  logic        pop_s;
  logic [18:0] head_s;
  logic [7:0]  head_x_s;
  logic [7:0]  head_y_s;
  logic [2:0]  head_col_s;
  logic        head_bad_s;

  assign in_ready_s   = (count_r < DEPTH_C);
  assign cmd.in_ready = in_ready_s;

  assign head_s     = mem_r[rd_ptr_r];
  assign head_x_s   = head_s[18:11];
  assign head_y_s   = head_s[10:3];
  assign head_col_s = head_s[2:0];
  assign head_bad_s = (head_x_s >= GRID_W_C) || (head_y_s >= GRID_H_C);

  assign busy       = (state_r != ST_IDLE) || (count_r != '0) || clear_pending_r;
  assign err        = err_r;
  assign vga_x      = vga_x_r;
  assign vga_y      = vga_y_r;
  assign vga_colour = vga_colour_r;
  assign vga_plot   = vga_plot_r;

  // FIFO handshakes: a pending clear always wins over the next command
  always_comb begin
    push_s = cmd.in_valid & in_ready_s;
    if ((state_r == ST_IDLE) && !clear_pending_r && (count_r != '0)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Command FIFO pointers, occupancy and storage
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {cmd.in_cell_x, cmd.in_cell_y, cmd.in_colour};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencer: chooses clear or next command in IDLE, then walks the pixel counters
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      clear_pending_r <= 1'b0;
      px_r            <= '0;
      py_r            <= '0;
      cx_r            <= '0;
      cy_r            <= '0;
      col_r           <= '0;
      vga_x_r         <= '0;
      vga_y_r         <= '0;
      vga_colour_r    <= '0;
      vga_plot_r      <= 1'b0;
      err_r           <= 1'b0;
    end else begin
      if (clear_req) begin
        clear_pending_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          vga_plot_r <= 1'b0;
          err_r      <= 1'b0;
          if (clear_pending_r) begin
            // A request held through the entry cycle stays pending
            clear_pending_r <= clear_req;
            px_r            <= '0;
            py_r            <= '0;
            state_r         <= ST_CLEAR;
          end else if (pop_s) begin
            cx_r  <= head_x_s;
            cy_r  <= head_y_s;
            col_r <= head_col_s;
            px_r  <= '0;
            py_r  <= '0;
            if (head_bad_s) begin
              err_r <= 1'b1;
            end else begin
              state_r <= ST_DRAW;
            end
          end
        end
        ST_DRAW: begin
          err_r        <= 1'b0;
          vga_x_r      <= 8'(X_OFF_C + ({1'b0, cx_r} * CELL_C) + {1'b0, px_r});
          vga_y_r      <= 8'(Y_OFF_C + ({1'b0, cy_r} * CELL_C) + {1'b0, py_r});
          vga_colour_r <= col_r;
          vga_plot_r   <= 1'b1;
          if (px_r == CELL_LAST) begin
            px_r <= '0;
            if (py_r == CELL_LAST) begin
              py_r    <= '0;
              state_r <= ST_IDLE;
            end else begin
              py_r <= py_r + 8'd1;
            end
          end else begin
            px_r <= px_r + 8'd1;
          end
        end
        ST_CLEAR: begin
          err_r        <= 1'b0;
          vga_x_r      <= px_r;
          vga_y_r      <= py_r;
          vga_colour_r <= CLEAR_COLOUR;
          vga_plot_r   <= 1'b1;
          if (px_r == SCR_X_LAST) begin
            px_r <= '0;
            if (py_r == SCR_Y_LAST) begin
              py_r    <= '0;
              state_r <= ST_IDLE;
            end else begin
              py_r <= py_r + 8'd1;
            end
          end else begin
            px_r <= px_r + 8'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          vga_plot_r <= 1'b0;
          err_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule
